// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keyboard receiver:
//               register offsets and decode selectors, AXI response codes,
//               STATUS/CTRL bit positions, FSM state types and the frame
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Register byte offsets; decode uses address bits [4:3]
    localparam logic [7:0] c_OFS_DATA   = 8'h00;
    localparam logic [7:0] c_OFS_STATUS = 8'h08;
    localparam logic [7:0] c_OFS_CTRL   = 8'h10;

    localparam logic [1:0] c_SEL_DATA   = c_OFS_DATA[4:3];
    localparam logic [1:0] c_SEL_STATUS = c_OFS_STATUS[4:3];
    localparam logic [1:0] c_SEL_CTRL   = c_OFS_CTRL[4:3];

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // DATA register
    localparam int c_DATA_VALID  = 8;

    // STATUS register
    localparam int c_ST_FERR     = 0;
    localparam int c_ST_OVF      = 1;
    localparam int c_ST_EMPTY    = 2;
    localparam int c_ST_FULL     = 3;
    localparam int c_ST_CNT_LSB  = 8;

    // CTRL register
    localparam int c_CTRL_EN     = 0;
    localparam int c_CTRL_IRQEN  = 1;

    typedef enum logic [0:0] {DF_IDLE = 1'b0, DF_RECV = 1'b1} deframe_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

    // Odd parity: XOR over data bits and parity bit must be 1
    function automatic logic parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_axi_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_axi_rx_if
// Description : AXI4 slave bus bundle for the PS/2 receiver.
//               slave modport  : used by the peripheral (ps2_axi_rx)
//               master modport : used by the crossbar / testbench
//               Channels: AW, W, B, AR, R (64-bit data, 4-bit IDs).
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_axi_rx_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_fifo
// Description : Circular-buffer FIFO for received scan codes.
//               A push is accepted when not full, or when full with a pop in
//               the same cycle. A rejected push pulses o_drop. A pop while
//               empty is ignored.
// Ports       : clock, resetn (sync, active-low)
//               i_push/i_din, i_pop, o_dout (head), o_full, o_empty,
//               o_count, o_drop
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_drop
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_drop  = i_push & w_full & ~w_do_pop;

endmodule
`default_nettype wire

// File: rtl/ps2_axi_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_axi_rx
// Description : PS/2 keyboard receiver with AXI4 slave register interface.
//               Synchronises ps2_clk/ps2_dat, deframes 11-bit frames, buffers
//               scan codes in a FIFO and exposes DATA/STATUS/CTRL registers.
// Ports       : clock, resetn (sync, active-low)
//               ps2_clk, ps2_dat : asynchronous PS/2 pins
//               irq              : registered level interrupt
//               io_slave         : AXI4 slave (ps2_axi_rx_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_axi_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         ps2_clk,
    input  logic         ps2_dat,
    output logic         irq,
    ps2_axi_rx_if.slave  io_slave
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- synchronisers and falling-edge strobe ----------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_sclk;
    logic                   w_sdat;
    logic                   w_strobe;

    // Reset to the idle-high bus level so release cannot fake an edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            r_clk_prev <= w_sclk;
        end
    end

    assign w_sclk   = r_clk_sync[SYNC_STAGES-1];
    assign w_sdat   = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe = r_clk_prev & ~w_sclk;

    // ---------------- deframer ----------------
    deframe_state_t r_dstate;
    logic [3:0]     r_bitcnt;
    logic [8:0]     r_shift;     // data[7:0] then parity in bit 8
    logic [TW-1:0]  r_tocnt;
    logic           w_frame_end;
    logic           w_frame_ok;
    logic           w_timeout;
    logic           w_ferr_set;

    // bitcnt==10 means this strobe carries the stop bit
    assign w_frame_end = w_strobe && (r_dstate == DF_RECV) && (r_bitcnt == 4'd10);
    assign w_frame_ok  = w_frame_end && parity_ok(r_shift) && w_sdat;
    assign w_timeout   = !w_strobe && (r_dstate == DF_RECV) && (r_tocnt == TW'(TIMEOUT_CYCLES));
    assign w_ferr_set  = (w_frame_end && !w_frame_ok) || w_timeout;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dstate <= DF_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tocnt  <= '0;
        end else begin
            case (r_dstate)
                DF_IDLE: begin
                    r_tocnt <= '0;
                    if (w_strobe && !w_sdat) begin
                        r_dstate <= DF_RECV;
                        r_bitcnt <= 4'd1;
                    end
                end
                DF_RECV: begin
                    if (w_strobe) begin
                        r_tocnt <= '0;
                        if (r_bitcnt == 4'd10) begin
                            r_dstate <= DF_IDLE;
                        end else begin
                            r_shift  <= {w_sdat, r_shift[8:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (w_timeout) begin
                        r_dstate <= DF_IDLE;
                    end else begin
                        r_tocnt <= r_tocnt + TW'(1);
                    end
                end
                default: r_dstate <= DF_IDLE;
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic             r_en;
    logic             r_irq_en;
    logic             r_ovf;
    logic             r_ferr;
    logic             r_irq;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_drop;

    assign w_push = w_frame_ok && r_en;

    ps2_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (r_shift[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    // ---------------- read channel ----------------
    rd_state_t   r_rstate;
    logic        r_arready;
    logic        r_rvalid;
    logic [63:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;
    logic [3:0]  r_rid;
    logic [1:0]  r_rsel;
    logic [7:0]  r_beats;
    logic [1:0]  w_rsel;
    logic [31:0] w_rval;
    logic [1:0]  w_rresp;

    // The first beat is built from the live AR address during the handshake
    assign w_rsel = (r_rstate == R_IDLE) ? io_slave.araddr[4:3] : r_rsel;
    assign w_pop  = (r_rstate == R_IDLE) && io_slave.arvalid
                    && (io_slave.araddr[4:3] == c_SEL_DATA);

    always_comb begin
        w_rval  = '0;
        w_rresp = c_RESP_OKAY;
        case (w_rsel)
            c_SEL_DATA: begin
                w_rval[c_DATA_VALID] = ~w_empty;
                w_rval[7:0]          = w_empty ? 8'h00 : w_head;
            end
            c_SEL_STATUS: begin
                w_rval[c_ST_CNT_LSB +: CNT_W] = w_count;
                w_rval[c_ST_FULL]             = w_full;
                w_rval[c_ST_EMPTY]            = w_empty;
                w_rval[c_ST_OVF]              = r_ovf;
                w_rval[c_ST_FERR]             = r_ferr;
            end
            c_SEL_CTRL: begin
                w_rval[c_CTRL_EN]    = r_en;
                w_rval[c_CTRL_IRQEN] = r_irq_en;
            end
            default: w_rresp = c_RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OKAY;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rsel    <= '0;
            r_beats   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (io_slave.arvalid) begin
                        r_rsel    <= io_slave.araddr[4:3];
                        r_rid     <= io_slave.arid;
                        r_beats   <= io_slave.arlen;
                        r_rlast   <= (io_slave.arlen == 8'd0);
                        r_rvalid  <= 1'b1;
                        r_rdata   <= {w_rval, w_rval};
                        r_rresp   <= w_rresp;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_rvalid && io_slave.rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            // Later beats re-read the register without popping
                            r_beats <= r_beats - 8'd1;
                            r_rlast <= (r_beats == 8'd1);
                            r_rdata <= {w_rval, w_rval};
                            r_rresp <= w_rresp;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wr_state_t  r_wstate;
    logic       r_awready;
    logic       r_wready;
    logic       r_bvalid;
    logic [1:0] r_bresp;
    logic [3:0] r_bid;
    logic [1:0] r_wsel;
    logic       w_wr_apply;
    logic       w_clr_ferr;
    logic       w_clr_ovf;

    // Only the wlast beat of a burst reaches the registers
    assign w_wr_apply = (r_wstate == W_DATA) && io_slave.wvalid && io_slave.wlast
                        && io_slave.wstrb[0];
    assign w_clr_ferr = w_wr_apply && (r_wsel == c_SEL_STATUS) && io_slave.wdata[c_ST_FERR];
    assign w_clr_ovf  = w_wr_apply && (r_wsel == c_SEL_STATUS) && io_slave.wdata[c_ST_OVF];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_bid     <= '0;
            r_wsel    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (io_slave.awvalid) begin
                        r_wsel    <= io_slave.awaddr[4:3];
                        r_bid     <= io_slave.awid;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (io_slave.wvalid && io_slave.wlast) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= ((r_wsel == c_SEL_STATUS) || (r_wsel == c_SEL_CTRL))
                                    ? c_RESP_OKAY : c_RESP_SLVERR;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (io_slave.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- control, sticky flags, interrupt ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_en     <= 1'b1;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_ferr   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_apply && (r_wsel == c_SEL_CTRL)) begin
                r_en     <= io_slave.wdata[c_CTRL_EN];
                r_irq_en <= io_slave.wdata[c_CTRL_IRQEN];
            end
            // A new error in the clearing cycle keeps the flag set
            r_ovf  <= (r_ovf  & ~w_clr_ovf)  | w_drop;
            r_ferr <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
            r_irq  <= r_irq_en & (~w_empty | r_ovf | r_ferr);
        end
    end

    assign irq              = r_irq;
    assign io_slave.arready = r_arready;
    assign io_slave.rvalid  = r_rvalid;
    assign io_slave.rdata   = r_rdata;
    assign io_slave.rresp   = r_rresp;
    assign io_slave.rlast   = r_rlast;
    assign io_slave.rid     = r_rid;
    assign io_slave.awready = r_awready;
    assign io_slave.wready  = r_wready;
    assign io_slave.bvalid  = r_bvalid;
    assign io_slave.bresp   = r_bresp;
    assign io_slave.bid     = r_bid;

    // Bus fields this register block does not decode
    logic w_unused;
    assign w_unused = ^{io_slave.awaddr[31:5], io_slave.awaddr[2:0], io_slave.awlen,
                        io_slave.awsize, io_slave.awburst, io_slave.araddr[31:5],
                        io_slave.araddr[2:0], io_slave.arsize, io_slave.arburst,
                        io_slave.wdata[63:2], io_slave.wstrb[7:1]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_axi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_axi_rx
// Description : Scoreboard testbench for ps2_axi_rx. A queue/flag model of
//               the receiver predicts every read beat and write response;
//               monitors compare whenever the DUT completes a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_axi_rx;
    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int H     = 6;      // PS/2 half bit period in system clocks

    logic clock   = 1'b0;
    logic resetn  = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic irq;

    ps2_axi_rx_if bus();

    ps2_axi_rx #(
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .irq      (irq),
        .io_slave (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;
    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    rexp_t r_e;
    bexp_t b_e;

    int n_cmp = 0;
    int n_err = 0;
    bit rr_rand = 1'b0;

    // Reference model of the receiver's architectural state
    byte unsigned mq[$];
    bit m_en = 1'b1, m_irqen = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] v = '0;
        v[11:8] = 4'(mq.size());
        v[3]    = (mq.size() == DEPTH);
        v[2]    = (mq.size() == 0);
        v[1]    = m_ovf;
        v[0]    = m_ferr;
        return v;
    endfunction

    function automatic bit m_irq();
        return m_irqen && (mq.size() != 0 || m_ovf || m_ferr);
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clock) begin
        #1;
        bus.rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.bready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (resetn && bus.rvalid && bus.rready) begin
            if (rq.size() == 0) begin
                fail_now("r_unexpected_beat");
            end else begin
                r_e = rq.pop_front();
                chk("rdata", bus.rdata, {r_e.data, r_e.data});
                chk("rresp", 64'(bus.rresp), 64'(r_e.resp));
                chk("rlast", 64'(bus.rlast), 64'(r_e.last));
                chk("rid",   64'(bus.rid),   64'(r_e.id));
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
                fail_now("b_unexpected_resp");
            end else begin
                b_e = bq.pop_front();
                chk("bresp", 64'(bus.bresp), 64'(b_e.resp));
                chk("bid",   64'(bus.bid),   64'(b_e.id));
            end
        end
    end

    // ---------------- PS/2 driver ----------------
    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(~(^c) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        tick(8);
        if (bad_par || bad_stop) begin
            m_ferr = 1'b1;
        end else if (m_en) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else m_ovf = 1'b1;
        end
    endtask

    // ---------------- AXI drivers ----------------
    task automatic wait_rq();
        int t = 0;
        while (rq.size() != 0 && t < 300) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (rq.size() != 0) begin
            fail_now("r_beats_timeout");
            rq.delete();
        end
    endtask

    task automatic axi_read(input logic [1:0] sel, input int len);
        logic [3:0]  id = 4'($urandom_range(0, 15));
        logic [31:0] v;
        int t = 0;
        for (int b = 0; b <= len; b++) begin
            v = 32'h0;
            case (sel)
                2'd0: if (mq.size() != 0) v = {23'h0, 1'b1, mq[0]};
                2'd1: v = m_status();
                2'd2: v = {30'h0, m_irqen, m_en};
                default: v = 32'h0;
            endcase
            if (b == 0 && sel == 2'd0 && mq.size() != 0) void'(mq.pop_front());
            rq.push_back('{data: v, resp: (sel == 2'd3) ? 2'b10 : 2'b00,
                           last: (b == len), id: id});
        end
        bus.arvalid = 1'b1;
        bus.araddr  = {27'($urandom), sel, 3'b000};
        bus.arlen   = 8'(len);
        bus.arid    = id;
        bus.arsize  = 3'd3;
        bus.arburst = 2'd0;
        @(negedge clock);
        while (!bus.arready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!bus.arready) fail_now("ar_handshake");
        @(posedge clock);
        #1;
        bus.arvalid = 1'b0;
        wait_rq();
    endtask

    task automatic axi_write(input logic [1:0] sel, input logic [31:0] d, input int nb);
        logic [3:0] id = 4'($urandom_range(0, 15));
        int t = 0;
        if (sel == 2'd2) begin
            m_en    = d[0];
            m_irqen = d[1];
        end else if (sel == 2'd1) begin
            if (d[0]) m_ferr = 1'b0;
            if (d[1]) m_ovf  = 1'b0;
        end
        bq.push_back('{resp: (sel == 2'd1 || sel == 2'd2) ? 2'b00 : 2'b10, id: id});
        bus.awvalid = 1'b1;
        bus.awaddr  = {27'($urandom), sel, 3'b000};
        bus.awid    = id;
        bus.awlen   = 8'(nb - 1);
        bus.awsize  = 3'd3;
        bus.awburst = 2'd1;
        @(negedge clock);
        while (!bus.awready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!bus.awready) fail_now("aw_handshake");
        @(posedge clock);
        #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.wvalid = 1'b1;
            bus.wstrb  = 8'hFF;
            bus.wlast  = (b == nb - 1);
            bus.wdata  = (b == nb - 1) ? {d, d} : {$urandom, $urandom};
            t = 0;
            @(negedge clock);
            while (!bus.wready && t < 100) begin
                @(negedge clock);
                t++;
            end
            if (!bus.wready) fail_now("w_handshake");
            @(posedge clock);
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        t = 0;
        while (bq.size() != 0 && t < 300) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (bq.size() != 0) begin
            fail_now("b_resp_timeout");
            bq.delete();
        end
    endtask

    task automatic check_irq();
        tick(3);
        chk("irq", 64'(irq), 64'(m_irq()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize  = '0;   bus.awburst = '0;
        bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize  = '0;   bus.arburst = '0;
        resetn = 1'b0;
        tick(5);
        resetn = 1'b1;
        tick(3);

        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_awready", 64'(bus.awready), 64'd1);
        chk("rst_wready",  64'(bus.wready),  64'd0);
        chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst_rlast",   64'(bus.rlast),   64'd0);
        chk("rst_rdata",   bus.rdata,        64'd0);
        chk("rst_rresp",   64'(bus.rresp),   64'd0);
        chk("rst_bresp",   64'(bus.bresp),   64'd0);
        chk("rst_rid",     64'(bus.rid),     64'd0);
        chk("rst_bid",     64'(bus.bid),     64'd0);
        chk("rst_irq",     64'(irq),         64'd0);
        axi_read(2'd2, 0);                   // CTRL reset value en=1
        axi_read(2'd1, 0);                   // STATUS: empty

        // Single good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b0);
        axi_read(2'd1, 0);
        axi_read(2'd0, 0);
        axi_read(2'd0, 0);

        // Parity error and W1C clear
        send_frame(8'h3C, 1'b1, 1'b0);
        axi_read(2'd1, 0);
        axi_write(2'd1, 32'h1, 1);
        axi_read(2'd1, 0);

        // Overflow: DEPTH+1 frames, then drain in order
        for (int c = 1; c <= DEPTH + 1; c++) send_frame(8'(c), 1'b0, 1'b0);
        axi_read(2'd1, 0);
        for (int i = 0; i < DEPTH; i++) axi_read(2'd0, 0);
        axi_write(2'd1, 32'h2, 2);
        axi_read(2'd1, 0);

        // Timeout of a partial frame, then recovery
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_dat = 1'b1;
        tick(TO + 40);
        m_ferr = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0);
        axi_read(2'd1, 0);
        axi_read(2'd0, 0);
        axi_write(2'd1, 32'h1, 1);

        // Interrupt assert and drain
        send_frame(8'($urandom), 1'b0, 1'b0);
        axi_write(2'd2, 32'h3, 1);
        check_irq();
        axi_read(2'd0, 0);
        check_irq();

        // Burst read of DATA with back-pressure
        rr_rand = 1'b1;
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'hBB, 1'b0, 1'b0);
        axi_read(2'd0, 2);
        axi_read(2'd1, 0);
        axi_read(2'd0, 0);
        axi_read(2'd3, 1);                   // unmapped
        axi_write(2'd0, 32'h0, 1);           // read-only DATA
        axi_write(2'd3, 32'h0, 1);           // unmapped

        // Randomised mix
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1: send_frame(8'($urandom), 1'b0, 1'b0);
                2: begin
                    bit bp = 1'($urandom_range(0, 1));
                    send_frame(8'($urandom), bp, !bp || 1'($urandom_range(0, 1)));
                end
                3: axi_read(2'($urandom_range(0, 3)), $urandom_range(0, 3));
                4: axi_write(2'd2, {30'($urandom), 1'($urandom_range(0, 1)),
                                    ($urandom_range(0, 3) != 0)}, $urandom_range(1, 3));
                5: axi_write(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 2));
                default: axi_read(2'd0, $urandom_range(0, 2));
            endcase
            check_irq();
        end
        axi_read(2'd1, 0);
        rr_rand = 1'b0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
